mem_test_responder: RTL



---
 rtl/mem_test_responder.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/mem_test_responder.sv
// mem_test_responder: single-port word memory on the val/rdy memory
// interface with a fixed-latency response pipeline, an in-order response
// queue and credit-based request flow control.
// Optional feature: define MEM_TEST_RESPONDER_RAND_STALL_EN to add an
// LFSR-driven random stall that holds off both req_rdy and resp_val.
//
// Handshake: a transfer happens on a rising clk edge where val && rdy;
// the sender holds msg stable while val is high and rdy is low.

package mem_msg_pkg;

  localparam logic [2:0] MEM_READ  = 3'd0;
  localparam logic [2:0] MEM_WRITE = 3'd1;
  localparam logic [2:0] MEM_INIT  = 3'd2;

  // "type" is a keyword, so the type field is called msg_type.
  typedef struct packed {
    logic [2:0]  msg_type;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  msg_type;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

endpackage

module mem_test_responder
  import mem_msg_pkg::*;
#(
  parameter int p_nwords  = 1024,
  parameter int p_latency = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  mem_req_4B_t  req_msg,
  input  logic         req_val,
  output logic         req_rdy,
  output mem_resp_4B_t resp_msg,
  output logic         resp_val,
  input  logic         resp_rdy
);

  localparam int IW = $clog2(p_nwords);
  localparam int QD = p_latency + 1;
  localparam int PW = $clog2(QD);
  localparam int CW = $clog2(2 * QD + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(QD - 1);
  localparam logic [CW-1:0] CREDITS  = CW'(QD);

  logic [31:0]   mem [p_nwords];
  logic [IW-1:0] idx;
  logic          accept;
  logic          push;
  logic          pop;
  logic          stall;
  logic [31:0]   word;
  logic [31:0]   rd_data;
  logic [31:0]   wr_data;
  logic [3:0]    wr_mask;
  mem_resp_4B_t  acc_resp;

  logic [p_latency-1:0] pipe_val;
  mem_resp_4B_t         pipe_msg [p_latency];
  mem_resp_4B_t         q_msg [QD];
  logic [PW-1:0]        wptr;
  logic [PW-1:0]        rptr;
  logic [CW-1:0]        q_count;
  logic [CW-1:0]        pipe_count;
  logic [CW-1:0]        inflight;
  logic                 unused_addr;

  // Address bits above the index alias onto the same word.
  assign idx         = req_msg.addr[IW+1:2];
  assign unused_addr = ^req_msg.addr[31:IW+2];

`ifdef MEM_TEST_RESPONDER_RAND_STALL_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR, taps 16,14,13,11, free running every cycle.
  always_ff @(posedge clk) begin
    if (reset) lfsr <= 16'hACE1;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // Size handling: extract/zero-extend read data and build the byte-lane
  // write mask with data replicated onto every lane it could land in.
  always_comb begin
    word    = mem[idx];
    rd_data = word;
    wr_data = req_msg.data;
    wr_mask = 4'hF;
    case (req_msg.len)
      2'd1: begin
        rd_data = (word >> {req_msg.addr[1:0], 3'b000}) & 32'h0000_00FF;
        wr_data = {4{req_msg.data[7:0]}};
        wr_mask = 4'b0001 << req_msg.addr[1:0];
      end
      2'd2: begin
        rd_data = (word >> {req_msg.addr[1], 4'b0000}) & 32'h0000_FFFF;
        wr_data = {2{req_msg.data[15:0]}};
        wr_mask = req_msg.addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        rd_data = word;
      end
    endcase
    acc_resp.msg_type = req_msg.msg_type;
    acc_resp.opaque   = req_msg.opaque;
    acc_resp.test     = 2'd0;
    acc_resp.len      = req_msg.len;
    acc_resp.data     = (req_msg.msg_type == MEM_READ) ? rd_data : 32'd0;
  end

  // Memory update on accepted WRITE/INIT; contents survive reset.
  always_ff @(posedge clk) begin
    if (accept && (req_msg.msg_type == MEM_WRITE || req_msg.msg_type == MEM_INIT)) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_mask[b]) mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Valid bits of the fixed-latency pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_val <= '0;
    end else begin
      pipe_val[0] <= accept;
      for (int i = 1; i < p_latency; i++) pipe_val[i] <= pipe_val[i-1];
    end
  end

  // Payload of the fixed-latency pipeline.
  always_ff @(posedge clk) begin
    pipe_msg[0] <= acc_resp;
    for (int i = 1; i < p_latency; i++) pipe_msg[i] <= pipe_msg[i-1];
  end

  assign push = pipe_val[p_latency-1];

  // Circular response queue pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr    <= '0;
      rptr    <= '0;
      q_count <= '0;
    end else begin
      if (push) wptr <= (wptr == PTR_LAST) ? '0 : wptr + PW'(1);
      if (pop)  rptr <= (rptr == PTR_LAST) ? '0 : rptr + PW'(1);
      case ({push, pop})
        2'b10:   q_count <= q_count + CW'(1);
        2'b01:   q_count <= q_count - CW'(1);
        default: q_count <= q_count;
      endcase
    end
  end

  // Response queue storage.
  always_ff @(posedge clk) begin
    if (push) q_msg[wptr] <= pipe_msg[p_latency-1];
  end

  // Credits: everything in the pipeline plus everything queued.
  always_comb begin
    pipe_count = '0;
    for (int i = 0; i < p_latency; i++) pipe_count = pipe_count + CW'(pipe_val[i]);
    inflight = pipe_count + q_count;
  end

  // The head popping this cycle frees a credit immediately, which is what
  // lets back-to-back requests run at one per cycle.
  assign resp_val = (q_count != '0) && !stall;
  assign resp_msg = q_msg[rptr];
  assign pop      = resp_val && resp_rdy;
  assign req_rdy  = !reset && !stall && ((inflight < CREDITS) || pop);
  assign accept   = req_val && req_rdy;

endmodule
